// File: rtl/window_scan_controller_pkg.sv
// Shared definitions for the window scan controller.
//   scan_state_e : frame sequencing states
//   clog2()      : counter width helper (floored at 1 bit)
//   *_DEF        : default geometry and the counter widths derived from it
package window_scan_controller_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  // Floored at 1 so a single-position dimension still gets a real bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    while (w < 32 && (64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

  localparam int unsigned IM_ROW_DEF  = 480;
  localparam int unsigned IM_COL_DEF  = 700;
  localparam int unsigned WIN_ROW_DEF = 16;
  localparam int unsigned WIN_COL_DEF = 16;
  localparam int unsigned ROW_W_DEF   = clog2(IM_ROW_DEF);
  localparam int unsigned COL_W_DEF   = clog2(IM_COL_DEF);

endpackage

// File: rtl/window_scan_controller_raster_position_counter.sv
// Raster row/column position of the next pixel to be accepted.
//   clk_i, rst_ni     : clock, async active-low reset
//   clr_i             : return to (0,0)
//   en_i              : advance one pixel in raster order (wraps after the frame)
//   row_o, col_o      : current position
//   end_of_row_c_o    : position is in the last column
//   end_of_frame_c_o  : position is the last pixel of the frame
module raster_position_counter
  import window_scan_controller_pkg::*;
#(
  parameter  int unsigned IM_ROW = IM_ROW_DEF,
  parameter  int unsigned IM_COL = IM_COL_DEF,
  localparam int unsigned ROW_W  = clog2(IM_ROW),
  localparam int unsigned COL_W  = clog2(IM_COL)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             end_of_row_c_o,
  output logic             end_of_frame_c_o
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  assign end_of_row_c_o   = (col_q == COL_W'(IM_COL - 1));
  assign end_of_frame_c_o = end_of_row_c_o && (row_q == ROW_W'(IM_ROW - 1));
  assign row_o            = row_q;
  assign col_o            = col_q;

  // Raster advance; the last pixel wraps straight back to the origin.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (end_of_row_c_o) begin
        col_d = '0;
        row_d = end_of_frame_c_o ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/window_scan_controller.sv
// Sequences one frame of raster pixels through the scan-line window buffer.
//   clock, reset          : clock, async active-low reset
//   frameStart            : start a frame (IDLE only)
//   pixValid / pixReady   : upstream pixel handshake
//   bufEnable             : buffer shift enable (accepted pixel)
//   winValid / winReady   : downstream window handshake
//   winRowIdx, winColIdx  : top-left corner of the presented window
//   busy                  : frame in progress (RUN or DRAIN)
//   frameDone             : one-cycle pulse after the last window is consumed
module window_scan_controller
  import window_scan_controller_pkg::*;
#(
  parameter  int unsigned imRow  = IM_ROW_DEF,
  parameter  int unsigned imCol  = IM_COL_DEF,
  parameter  int unsigned winRow = WIN_ROW_DEF,
  parameter  int unsigned winCol = WIN_COL_DEF,
  localparam int unsigned ROW_W  = clog2(imRow),
  localparam int unsigned COL_W  = clog2(imCol)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             frameStart,
  input  logic             pixValid,
  output logic             pixReady,
  output logic             bufEnable,
  output logic             winValid,
  input  logic             winReady,
  output logic [ROW_W-1:0] winRowIdx,
  output logic [COL_W-1:0] winColIdx,
  output logic             busy,
  output logic             frameDone
);

  scan_state_e      state_q, state_d;
  logic             win_valid_q, win_valid_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;

  logic [ROW_W-1:0] row_c;
  logic [COL_W-1:0] col_c;
  logic             end_of_row_c;
  logic             end_of_frame_c;
  logic             accept_c;
  logic             consume_c;
  logic             win_cond_c;
  logic             start_c;

  // Back-pressure only while a presented window is not being taken.
  assign pixReady  = (state_q == RUN) && (!win_valid_q || winReady);
  assign bufEnable = pixValid && pixReady;
  assign accept_c  = bufEnable;
  assign consume_c = win_valid_q && winReady;
  assign start_c   = (state_q == IDLE) && frameStart;

  // Window whose bottom-right is the accepted pixel lies fully inside the image;
  // the column term also rejects windows that would wrap across rows.
  assign win_cond_c = (row_c >= ROW_W'(winRow - 1)) && (col_c >= COL_W'(winCol - 1));

  raster_position_counter #(
    .IM_ROW (imRow),
    .IM_COL (imCol)
  ) u_pos (
    .clk_i            (clock),
    .rst_ni           (reset),
    .clr_i            (start_c),
    .en_i             (accept_c),
    .row_o            (row_c),
    .col_o            (col_c),
    .end_of_row_c_o   (end_of_row_c),
    .end_of_frame_c_o (end_of_frame_c)
  );

  // Next state and window flag/indices.
  always_comb begin
    state_d     = state_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;

    if (accept_c) begin
      win_valid_d = win_cond_c;
      win_row_d   = row_c - ROW_W'(winRow - 1);
      win_col_d   = col_c - COL_W'(winCol - 1);
    end else if (consume_c) begin
      win_valid_d = 1'b0;
    end

    case (state_q)
      IDLE:    if (frameStart) state_d = RUN;
      RUN:     if (accept_c && end_of_frame_c) state_d = DRAIN;
      // Leave as soon as the final window is gone after this edge.
      DRAIN:   if (!win_valid_d) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign winValid  = win_valid_q;
  assign winRowIdx = win_row_q;
  assign winColIdx = win_col_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign frameDone = (state_q == DONE);

  // end_of_row is folded into end_of_frame inside the counter.
  logic unused_c;
  assign unused_c = end_of_row_c;

endmodule
